// File: rtl/hex_entry_reg.sv
// Hex digit entry register: digits shift in from the right, with backspace,
// digit replace, direct word load and clear. Feeds a display scanner.
module hex_entry_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  nib,
    input  logic        nib_push,
    input  logic        pop,
    input  logic        load,
    input  logic [32:1] load_data,
    input  logic        clr,
    output logic [32:1] data,
    output logic [3:0]  ndigits,
    output logic        full,
    output logic        empty,
    output logic        ack,
    output logic        err
);

    logic nib_push_q;
    logic pop_q;
    logic push_e;
    logic pop_e;

    assign push_e = nib_push & ~nib_push_q;
    assign pop_e  = pop & ~pop_q;
    assign full   = (ndigits == 4'd8);
    assign empty  = (ndigits == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            data       <= '0;
            ndigits    <= 4'd0;
            err        <= 1'b0;
            ack        <= 1'b0;
            nib_push_q <= 1'b0;
            pop_q      <= 1'b0;
        end else begin
            // Edge history tracks the raw inputs even when an edge is discarded.
            nib_push_q <= nib_push;
            pop_q      <= pop;
            ack        <= 1'b0;
            if (clr) begin
                data    <= '0;
                ndigits <= 4'd0;
                err     <= 1'b0;
                ack     <= 1'b1;
            end else if (load) begin
                data    <= load_data;
                ndigits <= 4'd8;
                ack     <= 1'b1;
            end else if (push_e && pop_e && !empty) begin
                data[4:1] <= nib;
                ack       <= 1'b1;
            end else if (push_e) begin
                if (full) begin
                    err <= 1'b1;
                end else begin
                    data    <= {data[28:1], nib};
                    ndigits <= ndigits + 4'd1;
                    ack     <= 1'b1;
                end
            end else if (pop_e) begin
                if (empty) begin
                    err <= 1'b1;
                end else begin
                    data    <= {4'h0, data[32:5]};
                    ndigits <= ndigits - 4'd1;
                    ack     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hex_entry_reg.sv
// Bench for hex_entry_reg: directed vector table plus randomized run
// checked against a digit-list reference model.
module tb_hex_entry_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  nib = 4'h0;
    logic        nib_push = 1'b0;
    logic        pop = 1'b0;
    logic        load = 1'b0;
    logic [32:1] load_data = '0;
    logic        clr = 1'b0;
    logic [32:1] data;
    logic [3:0]  ndigits;
    logic        full;
    logic        empty;
    logic        ack;
    logic        err;

    always #5 clk = ~clk;

    hex_entry_reg dut (
        .clk(clk), .rst(rst), .nib(nib), .nib_push(nib_push), .pop(pop),
        .load(load), .load_data(load_data), .clr(clr), .data(data),
        .ndigits(ndigits), .full(full), .empty(empty), .ack(ack), .err(err)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference model: list of entered digits, oldest (leftmost) first.
    int  mq[$];
    bit  m_err, m_ack, m_pq, m_oq;

    function automatic void mstep(bit r, bit c, bit l, bit p, bit o,
                                  logic [3:0] n, logic [31:0] ld);
        bit pe, oe;
        if (r) begin
            mq.delete(); m_err = 0; m_ack = 0; m_pq = 0; m_oq = 0;
            return;
        end
        pe = p && !m_pq;
        oe = o && !m_oq;
        m_pq = p;
        m_oq = o;
        m_ack = 0;
        if (c) begin
            mq.delete(); m_err = 0; m_ack = 1;
        end else if (l) begin
            mq.delete();
            for (int i = 7; i >= 0; i--) mq.push_back(int'((ld >> (4 * i)) & 32'hF));
            m_ack = 1;
        end else if (pe && oe && mq.size() > 0) begin
            mq[mq.size() - 1] = int'(n);
            m_ack = 1;
        end else if (pe) begin
            if (mq.size() == 8) m_err = 1;
            else begin mq.push_back(int'(n)); m_ack = 1; end
        end else if (oe) begin
            if (mq.size() == 0) m_err = 1;
            else begin void'(mq.pop_back()); m_ack = 1; end
        end
    endfunction

    function automatic logic [31:0] mdata();
        logic [31:0] d = 0;
        foreach (mq[i]) d = (d << 4) | 32'(mq[i]);
        return d;
    endfunction

    task automatic drive(bit r, bit c, bit l, bit p, bit o,
                         logic [3:0] n, logic [31:0] ld);
        rst = r; clr = c; load = l; nib_push = p; pop = o;
        nib = n; load_data = ld;
        @(posedge clk);
        mstep(r, c, l, p, o, n, ld);
        #1;
    endtask

    typedef struct {
        bit          r, c, l, p, o;
        logic [3:0]  n;
        logic [31:0] ld;
        logic [31:0] e_data;
        int          e_nd;
        bit          e_ack, e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(bit r, bit c, bit l, bit p, bit o, logic [3:0] n,
                              logic [31:0] ld, logic [31:0] ed, int nd,
                              bit a, bit e);
        vec_t t;
        t.r = r; t.c = c; t.l = l; t.p = p; t.o = o; t.n = n; t.ld = ld;
        t.e_data = ed; t.e_nd = nd; t.e_ack = a; t.e_err = e;
        vecs.push_back(t);
    endfunction

    initial begin
        //  r c l p o nib ld            data          nd ack err
        v(1,0,0,0,0,4'h0,32'h0,        32'h0,         0, 0, 0);
        v(0,0,0,1,0,4'h1,32'h0,        32'h1,         1, 1, 0);
        v(0,0,0,0,0,4'h0,32'h0,        32'h1,         1, 0, 0);
        v(0,0,0,1,0,4'h2,32'h0,        32'h12,        2, 1, 0);
        v(0,0,0,0,0,4'h0,32'h0,        32'h12,        2, 0, 0);
        v(0,0,0,1,0,4'h3,32'h0,        32'h123,       3, 1, 0);
        v(0,0,0,0,0,4'h0,32'h0,        32'h123,       3, 0, 0);
        v(0,0,0,1,0,4'h4,32'h0,        32'h1234,      4, 1, 0);
        v(0,0,0,0,0,4'h0,32'h0,        32'h1234,      4, 0, 0);
        v(0,0,0,1,0,4'h5,32'h0,        32'h12345,     5, 1, 0);
        v(0,0,0,0,0,4'h0,32'h0,        32'h12345,     5, 0, 0);
        v(0,0,0,1,0,4'h6,32'h0,        32'h123456,    6, 1, 0);
        v(0,0,0,0,0,4'h0,32'h0,        32'h123456,    6, 0, 0);
        v(0,0,0,1,0,4'h7,32'h0,        32'h1234567,   7, 1, 0);
        v(0,0,0,0,0,4'h0,32'h0,        32'h1234567,   7, 0, 0);
        v(0,0,0,1,0,4'h8,32'h0,        32'h12345678,  8, 1, 0);
        v(0,0,0,0,0,4'h0,32'h0,        32'h12345678,  8, 0, 0);
        // push while full, then clear
        v(0,0,0,1,0,4'h9,32'h0,        32'h12345678,  8, 0, 1);
        v(0,0,0,0,0,4'h0,32'h0,        32'h12345678,  8, 0, 1);
        v(0,1,0,0,0,4'h0,32'h0,        32'h0,         0, 1, 0);
        v(0,0,0,0,0,4'h0,32'h0,        32'h0,         0, 0, 0);
        // AB then pops down past empty
        v(0,0,0,1,0,4'hA,32'h0,        32'hA,         1, 1, 0);
        v(0,0,0,0,0,4'h0,32'h0,        32'hA,         1, 0, 0);
        v(0,0,0,1,0,4'hB,32'h0,        32'hAB,        2, 1, 0);
        v(0,0,0,0,0,4'h0,32'h0,        32'hAB,        2, 0, 0);
        v(0,0,0,0,1,4'h0,32'h0,        32'hA,         1, 1, 0);
        v(0,0,0,0,0,4'h0,32'h0,        32'hA,         1, 0, 0);
        v(0,0,0,0,1,4'h0,32'h0,        32'h0,         0, 1, 0);
        v(0,0,0,0,0,4'h0,32'h0,        32'h0,         0, 0, 0);
        v(0,0,0,0,1,4'h0,32'h0,        32'h0,         0, 0, 1);
        v(0,0,0,0,0,4'h0,32'h0,        32'h0,         0, 0, 1);
        // clear, then hold push of F for 20 cycles
        v(0,1,0,0,0,4'h0,32'h0,        32'h0,         0, 1, 0);
        v(0,0,0,1,0,4'hF,32'h0,        32'hF,         1, 1, 0);
        for (int i = 0; i < 19; i++)
            v(0,0,0,1,0,4'hF,32'h0,    32'hF,         1, 0, 0);
        v(0,0,0,0,0,4'h0,32'h0,        32'hF,         1, 0, 0);
        // load beats a concurrent push, then digit replace
        v(0,0,1,1,0,4'h1,32'hFEDCBA98, 32'hFEDCBA98, 8, 1, 0);
        v(0,0,0,0,0,4'h0,32'h0,        32'hFEDCBA98, 8, 0, 0);
        v(0,0,0,1,1,4'h3,32'h0,        32'hFEDCBA93, 8, 1, 0);
        v(0,0,0,0,0,4'h0,32'h0,        32'hFEDCBA93, 8, 0, 0);
        // reset beats load
        v(1,0,1,0,0,4'h0,32'h12345678, 32'h0,         0, 0, 0);
        v(0,0,0,0,0,4'h0,32'h0,        32'h0,         0, 0, 0);
        // push held through reset release
        v(1,0,0,1,0,4'h7,32'h0,        32'h0,         0, 0, 0);
        v(0,0,0,1,0,4'h7,32'h0,        32'h7,         1, 1, 0);
        v(0,0,0,1,0,4'h7,32'h0,        32'h7,         1, 0, 0);
        v(0,0,0,0,0,4'h0,32'h0,        32'h7,         1, 0, 0);
        // push+pop on empty acts as a push
        v(0,1,0,0,0,4'h0,32'h0,        32'h0,         0, 1, 0);
        v(0,0,0,1,1,4'hC,32'h0,        32'hC,         1, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].c, vecs[i].l, vecs[i].p, vecs[i].o,
                  vecs[i].n, vecs[i].ld);
            chk($sformatf("v%0d data", i), data, vecs[i].e_data);
            chk($sformatf("v%0d ndigits", i), 32'(ndigits), 32'(vecs[i].e_nd));
            chk($sformatf("v%0d ack", i), 32'(ack), 32'(vecs[i].e_ack));
            chk($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].e_err));
            chk($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].e_nd == 8));
            chk($sformatf("v%0d empty", i), 32'(empty), 32'(vecs[i].e_nd == 0));
        end

        drive(1, 0, 0, 0, 0, 4'h0, 32'h0);
        for (int i = 0; i < 1500; i++) begin
            bit r, c, l, p, o;
            r = ($urandom_range(0, 99) == 0);
            c = ($urandom_range(0, 29) == 0);
            l = ($urandom_range(0, 29) == 0);
            p = ($urandom_range(0, 99) < 55);
            o = ($urandom_range(0, 99) < 35);
            drive(r, c, l, p, o, 4'($urandom), 32'($urandom));
            chk($sformatf("r%0d data", i), data, mdata());
            chk($sformatf("r%0d ndigits", i), 32'(ndigits), 32'(mq.size()));
            chk($sformatf("r%0d ack", i), 32'(ack), 32'(m_ack));
            chk($sformatf("r%0d err", i), 32'(err), 32'(m_err));
            chk($sformatf("r%0d full", i), 32'(full), 32'(mq.size() == 8));
            chk($sformatf("r%0d empty", i), 32'(empty), 32'(mq.size() == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_entry_reg.md
HEX_ENTRY_REG -- requirements
Module: hex_entry_reg

Parameters
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.

Interface
REQ-002 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 nib  in  4  hex digit to enter.
REQ-005 nib_push  in  1  push request, level input (may be held many cycles); one entry per rising edge.
REQ-006 pop  in  1  backspace request, level input; one removal per rising edge.
REQ-007 load  in  1  level; while high, load_data SHALL be loaded every cycle.
REQ-008 load_data  in  32 [32:1]  full word for direct load.
REQ-009 clr  in  1  level; while high, the word SHALL be cleared every cycle.
REQ-010 data  out  32 [32:1]  registered word feeding the display scanner; [32:29] is the leftmost digit, [4:1] the rightmost.
REQ-011 ndigits  out  4  count of entered digits, range 0..8.
REQ-012 full  out  1  ndigits == 8 (combinational from the register).
REQ-013 empty  out  1  ndigits == 0 (combinational from the register).
REQ-014 ack  out  1  one-cycle pulse for each accepted operation.
REQ-015 err  out  1  sticky flag for a rejected push or pop.

Function
REQ-016 Edge detection: the block SHALL register nib_push and pop each cycle. push_e = nib_push & ~nib_push_q. pop_e = pop & ~pop_q.
REQ-017 Priority each cycle SHALL be rst > clr > load > push_e/pop_e.
REQ-018 clr: data=0, ndigits=0, err=0, ack=1.
REQ-019 load: data=load_data, ndigits=8, ack=1; err unchanged; any concurrent edges SHALL be discarded.
REQ-020 push_e only, not full: data={data[28:1], nib}, ndigits+1, ack=1.
REQ-021 push_e only, full: data and ndigits unchanged, err=1, ack=0.
REQ-022 pop_e only, not empty: data={4'h0, data[32:5]}, ndigits-1, ack=1.
REQ-023 pop_e only, empty: no change, err=1, ack=0.
REQ-024 push_e and pop_e together, not empty: data[4:1]=nib (digit replace), ndigits unchanged, ack=1.
REQ-025 push_e and pop_e together, empty: the block SHALL behave as a push.
REQ-026 Latency: every operation SHALL be visible on data/ndigits/ack on the cycle after the rising edge at which the input was first sampled high.
REQ-027 A held nib_push or pop SHALL cause exactly one operation until it is deasserted for at least one cycle.
REQ-028 ndigits SHALL never exceed 8 or wrap below 0.
REQ-029 data SHALL be a stable register output with no glitches, safe for an asynchronous-rate scanner.

Reset
REQ-030 rst SHALL set: data=0, ndigits=0, err=0, ack=0, nib_push_q=0, pop_q=0.
REQ-031 rst asserted mid-operation SHALL override every other input in that cycle.
REQ-032 A nib_push held high through reset release SHALL produce one push on the first cycle after release.

Verification
REQ-033 Reset, then push nibbles 1,2,...,8 as separate pulses -> data=32'h1234_5678, ndigits=8, full=1, 8 ack pulses.
REQ-034 From the full state, push 9 -> data unchanged, err=1, no ack; then clr -> data=0, err=0, empty=1.
REQ-035 data=32'h0000_00AB, ndigits=2; pop -> data=32'h0000_000A, ndigits=1; two more pops -> empty=1, err=1.
REQ-036 Hold nib_push=1 with nib=F for 20 cycles from empty -> exactly one push, data=32'h0000_000F, one ack.
REQ-037 load=1 with load_data=32'hFEDC_BA98 and push_e in the same cycle -> data=32'hFEDC_BA98, ndigits=8; then push and pop together with nib=3 -> data=32'hFEDC_BA93.
REQ-038 rst asserted in the same cycle as load -> data=0, ndigits=0, ack=0.
